// File: rtl/pc_pkg.sv
// Shared opcode encoding and default parameter values for the program sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_NEXT   = 3'd1,
        OP_JUMP   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5
    } pc_op_e;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_INC          = 4;
    localparam int DEF_RESET_VECTOR = 0;
    localparam int DEF_RAS_DEPTH    = 8;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module ras_stack #(
    parameter  int WIDTH     = 32,
    parameter  int RAS_DEPTH = 8,
    localparam int CW        = $clog2(RAS_DEPTH + 1),
    localparam int PW        = $clog2(RAS_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n_a,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    top_reg, top_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [PW-1:0]    wr_ptr;

    assign full   = (count_reg == CW'(RAS_DEPTH));
    assign empty  = (count_reg == '0);
    assign count  = count_reg;
    // Top of stack is read straight from storage so a RET right after a CALL sees the new entry.
    assign dout   = mem[top_reg];
    // The pointer is a power-of-two width, so incrementing wraps around the ring for free.
    assign wr_ptr = top_reg + 1'b1;
    assign ovf    = en & push & full;
    assign unf    = en & pop & ~push & empty;

    // Pointer and occupancy update; count saturates on overflow, pop on empty is ignored.
    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        if (en && push) begin
            top_next = wr_ptr;
            if (!full) begin
                count_next = count_reg + 1'b1;
            end
        end else if (en && pop && !empty) begin
            top_next   = top_reg - 1'b1;
            count_next = count_reg - 1'b1;
        end
    end

    // Pointer/count registers; storage contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst_n_a) begin
            top_reg   <= '0;
            count_reg <= '0;
        end else begin
            top_reg   <= top_next;
            count_reg <= count_next;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (en && push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address sequencer: opcode mux, PC register, return-address stack and sticky errors.
module program_sequencer
    import pc_pkg::*;
#(
    parameter  int               WIDTH        = DEF_WIDTH,
    parameter  int               INC          = DEF_INC,
    parameter  logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter  int               RAS_DEPTH    = DEF_RAS_DEPTH,
    localparam int               CW           = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n_a,
    input  logic             stall,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] offset,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc,
    output logic [CW-1:0]    ras_count,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ovf_err,
    output logic             unf_err
);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ras_dout;
    logic             ras_push, ras_pop;
    logic             ras_ovf, ras_unf;
    logic             ovf_err_reg, ovf_err_next;
    logic             unf_err_reg, unf_err_next;
    pc_op_e           op_e;

    assign op_e    = pc_op_e'(op);
    assign pc_inc  = pc_reg + WIDTH'(INC);
    assign pc      = pc_reg;
    assign ovf_err = ovf_err_reg;
    assign unf_err = unf_err_reg;

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n_a (rst_n_a),
        .en      (~stall),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (pc_inc),
        .dout    (ras_dout),
        .count   (ras_count),
        .full    (ras_full),
        .empty   (ras_empty),
        .ovf     (ras_ovf),
        .unf     (ras_unf)
    );

    // Opcode mux; unused codes fall through to hold, and a stall freezes the PC.
    always_comb begin
        pc_next  = pc_reg;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        case (op_e)
            OP_NEXT:   pc_next = pc_inc;
            OP_JUMP:   pc_next = target;
            OP_BRANCH: pc_next = pc_reg + offset;
            OP_CALL: begin
                ras_push = 1'b1;
                pc_next  = target;
            end
            OP_RET: begin
                ras_pop = 1'b1;
                pc_next = ras_empty ? pc_inc : ras_dout;
            end
            default:   pc_next = pc_reg;
        endcase
        if (stall) begin
            pc_next = pc_reg;
        end
    end

    // Sticky error flags: a new event wins over a simultaneous clear.
    always_comb begin
        ovf_err_next = ovf_err_reg;
        unf_err_next = unf_err_reg;
        if (err_clr) begin
            ovf_err_next = 1'b0;
            unf_err_next = 1'b0;
        end
        if (ras_ovf) begin
            ovf_err_next = 1'b1;
        end
        if (ras_unf) begin
            unf_err_next = 1'b1;
        end
    end

    // PC and error-flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n_a) begin
            pc_reg      <= RESET_VECTOR;
            ovf_err_reg <= 1'b0;
            unf_err_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            ovf_err_reg <= ovf_err_next;
            unf_err_reg <= unf_err_next;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: directed vector table, hand-written overflow/reset sequence, random vs. model.
module tb_program_sequencer;

    localparam int          W     = 32;
    localparam int          DEPTH = 4;
    localparam int          CWB   = $clog2(DEPTH + 1);
    localparam logic [31:0] RV    = 32'h100;

    localparam logic [2:0] HOLD = 3'd0, NEXT = 3'd1, JUMP = 3'd2, BRANCH = 3'd3,
                           CALL = 3'd4, RET = 3'd5;

    logic           clk = 1'b0;
    logic           rst_n_a = 1'b0;
    logic           stall = 1'b0;
    logic [2:0]     op = 3'd0;
    logic [W-1:0]   target = '0;
    logic [W-1:0]   offset = '0;
    logic           err_clr = 1'b0;
    logic [W-1:0]   pc;
    logic [CWB-1:0] ras_count;
    logic           ras_full, ras_empty, ovf_err, unf_err;

    int checks = 0;
    int failures = 0;

    program_sequencer #(
        .WIDTH        (W),
        .INC          (4),
        .RESET_VECTOR (RV),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n_a   (rst_n_a),
        .stall     (stall),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .err_clr   (err_clr),
        .pc        (pc),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] target;
        logic [31:0] offset;
        logic        stall;
        logic        err_clr;
        logic [31:0] exp_pc;
        int          exp_count;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: PC as a number, RAS as a queue of return addresses (back = most recent).
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input int e_cnt,
                             input logic e_ovf, input logic e_unf);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".ras_count"}, 32'(ras_count), 32'(e_cnt));
        chk({tag, ".ras_full"}, 32'(ras_full), 32'(e_cnt == DEPTH));
        chk({tag, ".ras_empty"}, 32'(ras_empty), 32'(e_cnt == 0));
        chk({tag, ".ovf_err"}, 32'(ovf_err), 32'(e_ovf));
        chk({tag, ".unf_err"}, 32'(unf_err), 32'(e_unf));
    endtask

    // Drive one cycle's inputs, let the edge happen, and settle just after it.
    task automatic step(input logic r, input logic [2:0] o, input logic [31:0] t,
                        input logic [31:0] off, input logic s, input logic c);
        rst_n_a = r; op = o; target = t; offset = off; stall = s; err_clr = c;
        @(posedge clk);
        #1;
        $display("txn rst_n=%0d op=%0d tgt=%08h off=%08h stall=%0d clr=%0d -> pc=%08h cnt=%0d ovf=%0d unf=%0d",
                 r, o, t, off, s, c, pc, ras_count, ovf_err, unf_err);
    endtask

    task automatic model_step(input logic r, input logic [2:0] o, input logic [31:0] t,
                              input logic [31:0] off, input logic s, input logic c);
        logic set_o, set_u;
        set_o = 1'b0;
        set_u = 1'b0;
        if (!r) begin
            m_pc = RV;
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        if (!s) begin
            if (o == NEXT) m_pc = m_pc + 32'd4;
            else if (o == JUMP) m_pc = t;
            else if (o == BRANCH) m_pc = m_pc + off;
            else if (o == CALL) begin
                m_q.push_back(m_pc + 32'd4);
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    set_o = 1'b1;
                end
                m_pc = t;
            end else if (o == RET) begin
                if (m_q.size() > 0) m_pc = m_q.pop_back();
                else begin
                    m_pc = m_pc + 32'd4;
                    set_u = 1'b1;
                end
            end
        end
        if (set_o) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (set_u) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] t, input logic [31:0] off,
                                input logic s, input logic c, input logic [31:0] p, input int n,
                                input logic ov, input logic un);
        vec_t v;
        v.op = o; v.target = t; v.offset = off; v.stall = s; v.err_clr = c;
        v.exp_pc = p; v.exp_count = n; v.exp_ovf = ov; v.exp_unf = un;
        return v;
    endfunction

    initial begin
        logic [31:0] ret_exp[4];
        // Directed vectors, expectations worked out by hand.
        vecs.push_back(mk(NEXT,   0, 0, 0, 0, 32'h104, 0, 0, 0));
        vecs.push_back(mk(NEXT,   0, 0, 0, 0, 32'h108, 0, 0, 0));
        vecs.push_back(mk(NEXT,   0, 0, 0, 0, 32'h10C, 0, 0, 0));
        vecs.push_back(mk(JUMP,   32'h200, 0, 0, 0, 32'h200, 0, 0, 0));
        vecs.push_back(mk(BRANCH, 0, 32'hFFFF_FFF0, 0, 0, 32'h1F0, 0, 0, 0));
        vecs.push_back(mk(JUMP,   32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(NEXT,   0, 0, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(JUMP,   32'h10, 0, 0, 0, 32'h10, 0, 0, 0));
        vecs.push_back(mk(CALL,   32'h40, 0, 0, 0, 32'h40, 1, 0, 0));
        vecs.push_back(mk(CALL,   32'h80, 0, 0, 0, 32'h80, 2, 0, 0));
        vecs.push_back(mk(RET,    0, 0, 0, 0, 32'h44, 1, 0, 0));
        vecs.push_back(mk(RET,    0, 0, 0, 0, 32'h14, 0, 0, 0));
        vecs.push_back(mk(3'd6,   32'h999, 0, 0, 0, 32'h14, 0, 0, 0));
        vecs.push_back(mk(3'd7,   32'h999, 0, 0, 0, 32'h14, 0, 0, 0));
        vecs.push_back(mk(RET,    0, 0, 0, 0, 32'h18, 0, 0, 1));
        vecs.push_back(mk(NEXT,   0, 0, 0, 1, 32'h1C, 0, 0, 0));
        vecs.push_back(mk(CALL,   32'h300, 0, 1, 0, 32'h1C, 0, 0, 0));
        vecs.push_back(mk(CALL,   32'h300, 0, 1, 0, 32'h1C, 0, 0, 0));
        vecs.push_back(mk(CALL,   32'h300, 0, 1, 0, 32'h1C, 0, 0, 0));
        vecs.push_back(mk(CALL,   32'h300, 0, 0, 0, 32'h300, 1, 0, 0));
        vecs.push_back(mk(RET,    0, 0, 0, 0, 32'h20, 0, 0, 0));
        vecs.push_back(mk(RET,    0, 0, 1, 0, 32'h20, 0, 0, 0));

        // Reset state.
        step(0, NEXT, 0, 0, 1, 0);
        check_all("reset", RV, 0, 0, 0);

        foreach (vecs[i]) begin
            step(1, vecs[i].op, vecs[i].target, vecs[i].offset, vecs[i].stall, vecs[i].err_clr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_count,
                      vecs[i].exp_ovf, vecs[i].exp_unf);
        end

        // Overflow: eight calls from pc=0x20, clear, then a ninth call with a simultaneous clear.
        for (int i = 0; i < 8; i++) begin
            step(1, CALL, 32'h1000 + 32'(i) * 32'h10, 0, 0, 0);
        end
        check_all("ovf8", 32'h1070, 4, 1, 0);
        step(1, HOLD, 0, 0, 0, 1);
        check_all("ovf_clr", 32'h1070, 4, 0, 0);
        step(1, CALL, 32'h1080, 0, 0, 1);
        check_all("ovf_set_wins", 32'h1080, 4, 1, 0);
        step(1, HOLD, 0, 0, 0, 1);
        check_all("ovf_clr2", 32'h1080, 4, 0, 0);
        ret_exp[0] = 32'h1074; ret_exp[1] = 32'h1064; ret_exp[2] = 32'h1054; ret_exp[3] = 32'h1044;
        for (int i = 0; i < 4; i++) begin
            step(1, RET, 0, 0, 0, 0);
            check_all($sformatf("lifo%0d", i), ret_exp[i], 3 - i, 0, 0);
        end
        step(1, RET, 0, 0, 0, 0);
        check_all("unf_ret", 32'h1048, 0, 0, 1);

        // Reset in the middle of a call chain, with stall asserted.
        step(1, CALL, 32'h500, 0, 0, 0);
        step(1, CALL, 32'h600, 0, 0, 0);
        step(0, CALL, 32'h700, 0, 1, 0);
        check_all("mid_reset", RV, 0, 0, 0);
        step(1, RET, 0, 0, 0, 0);
        check_all("post_reset_ret", RV + 32'd4, 0, 0, 1);

        // Random stimulus against the model.
        step(0, HOLD, 0, 0, 0, 0);
        model_step(0, HOLD, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic        r, s, c;
            logic [2:0]  o;
            logic [31:0] t, off;
            int          sel;
            r   = ($urandom_range(0, 99) != 0);
            s   = ($urandom_range(0, 7) == 0);
            c   = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 9);
            o   = (sel < 3) ? CALL : (sel < 6) ? RET : 3'($urandom_range(0, 7));
            t   = $urandom;
            off = $urandom;
            step(r, o, t, off, s, c);
            model_step(r, o, t, off, s, c);
            check_all($sformatf("rnd%0d", i), m_pc, m_q.size(), m_ovf, m_unf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised successor to the single-register program counter. It holds the fetch address and updates it once per cycle from a one-hot-free opcode: hold, sequential increment, absolute jump, PC-relative branch, call or return. Calls and returns go through an internal circular return-address stack (RAS) with overflow/underflow reporting. It sits between the control unit (which supplies `op`, `target`, `offset`) and instruction fetch (which consumes `pc`).

## Interface
- `WIDTH`, 32: PC and address width in bits.
- `INC`, 4: sequential step added by NEXT and used for the call return address.
- `RESET_VECTOR`, 0: value loaded into `pc` on reset.
- `RAS_DEPTH`, 8: return-address stack entries; power of two, ≥2.
- `CW`, `$clog2(RAS_DEPTH+1)`: derived width of `ras_count`; localparam, not overridable.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n_a`  in  1  reset, synchronous, active-low; sampled on `clk` rising edge.
- `stall`  in  1  freeze `pc` and RAS this cycle.
- `op`  in  3  `pc_op_e` opcode.
- `target`  in  WIDTH  absolute address for JUMP/CALL.
- `offset`  in  WIDTH  two's-complement displacement for BRANCH.
- `err_clr`  in  1  clear sticky error flags.
- `pc`  out  WIDTH  current fetch address (registered).
- `ras_count`  out  CW  valid RAS entries, 0..RAS_DEPTH.
- `ras_full`  out  1  `ras_count == RAS_DEPTH`.
- `ras_empty`  out  1  `ras_count == 0`.
- `ovf_err`  out  1  sticky: a CALL overwrote the oldest entry.
- `unf_err`  out  1  sticky: a RET was issued with the RAS empty.

## Operation
- Opcodes: HOLD=0, NEXT=1, JUMP=2, BRANCH=3, CALL=4, RET=5. Codes 6 and 7 behave as HOLD.
- HOLD: `pc` unchanged.
- NEXT: `pc <= pc + INC`.
- JUMP: `pc <= target`.
- BRANCH: `pc <= pc + offset`.
- CALL: push `pc + INC`, then `pc <= target`.
  - If the RAS is full, the push overwrites the oldest entry (circular buffer).
  - `ras_count` stays at RAS_DEPTH and `ovf_err` is set.
- RET with RAS not empty: `pc <=` top of stack, pop, `ras_count` decrements.
- RET with RAS empty: `pc <= pc + INC`, `ras_count` stays 0, `unf_err` is set.
- All arithmetic is modulo 2^WIDTH and wraps silently. No alignment check is made.
- `stall=1`: `pc`, RAS contents and `ras_count` hold regardless of `op`. No error flag can be set during a stall.
- `err_clr` acts whether or not `stall` is asserted. If a new error event and `err_clr` occur in the same cycle, the set wins.
- Reset (`rst_n_a=0` at an edge) has priority over everything, including `stall`:
  - `pc=RESET_VECTOR`, `ras_count=0`, `ras_empty=1`, `ras_full=0`, `ovf_err=0`, `unf_err=0`.
  - RAS storage is not cleared; it is don't-care.
- Reset in the middle of a call chain discards all return addresses.

## Timing
- Every output is registered, or decoded from registers only.
- `op`, `target`, `offset` and `stall` are sampled at edge N. The new `pc` is visible after edge N; latency is 1 cycle.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate.
  - CALL at N followed by RET at N+1 returns `pc` to the pre-call `pc + INC` after edge N+1.
- `ras_count`, `ras_full`, `ras_empty` and the error flags update on the same edge as `pc`.
- There is no combinational path from any input to any output.

## Structure
- Package `pc_pkg`:
  - `typedef enum logic [2:0] pc_op_e` holding the opcode values.
  - Reset-default localparams.
- Sub-module `ras_stack #(WIDTH, RAS_DEPTH)`: circular LIFO.
  - Storage array, top pointer, count.
  - Inputs `push`, `pop`, `din`, `en`; outputs `dout` (top), `count`, `full`, `empty`, `ovf`, `unf` (single-cycle pulses).
  - Push while full: advance pointer, overwrite, count saturates.
  - Pop while empty: no change.
- `program_sequencer` contains the opcode mux, PC register and sticky error flags.

## Test plan
- Reset then NEXT ×3 with INC=4, RESET_VECTOR=0x100 → `pc` 0x100, 0x104, 0x108, 0x10C; `ras_empty=1`.
- `pc=0x200`, BRANCH `offset=0xFFFFFFF0` → `pc=0x1F0`; JUMP `target=0xFFFFFFFC` then NEXT → `pc=0x0` (wrap).
- Nested calls at 0x10 → 0x40 → 0x80, then RET ×2 → `pc` 0x44 then 0x14; `ras_count` 1, 2, 1, 0.
- RAS_DEPTH=4: nine CALLs → `ras_count=4`, `ras_full=1`, `ovf_err=1`. Four RETs return the four most recent return addresses in LIFO order. A fifth RET gives `pc+4` and `unf_err=1`.
- `stall=1` with CALL held for 3 cycles → `pc` and `ras_count` unchanged. Releasing `stall` performs exactly one push.
- `err_clr` pulsed together with an overflowing CALL → `ovf_err` stays 1. A later `err_clr` alone → 0. `rst_n_a=0` mid-chain → `pc=RESET_VECTOR`, `ras_count=0` on the next edge.
